// File: rtl/matrix_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : matrix_alu_seq
// Brief    : Sequential DIM x DIM signed matrix ALU (add, sub, transpose,
//            scalar multiply, matrix multiply) with saturation and handshake.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_alu_seq #(
    parameter int DIM        = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SATURATE   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_enable,
    input  logic [2:0]                        i_operation,
    input  logic [DATA_WIDTH-1:0]             i_scalar,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]     i_matrix_a,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]     i_matrix_b,
    output logic [DIM*DIM*DATA_WIDTH-1:0]     o_result,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_overflow
);

    localparam int c_DW = DATA_WIDTH;
    localparam int c_IW = $clog2(DIM);
    localparam int c_XW = $clog2(DIM*DIM);
    localparam int c_PW = 2*DATA_WIDTH;
    localparam int c_AW = 2*DATA_WIDTH + $clog2(DIM);
    localparam int c_MW = DIM*DIM*DATA_WIDTH;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COMPUTE = 2'd1;
    localparam logic [1:0] c_FINISH  = 2'd2;

    localparam logic [2:0] c_OP_ADD  = 3'b001;
    localparam logic [2:0] c_OP_SUB  = 3'b010;
    localparam logic [2:0] c_OP_TRAN = 3'b011;
    localparam logic [2:0] c_OP_SMUL = 3'b100;
    localparam logic [2:0] c_OP_MM   = 3'b101;

    localparam logic [c_IW-1:0] c_DMAX = c_IW'(DIM-1);
    localparam logic [c_DW-1:0] c_MIN  = {1'b1, {(c_DW-1){1'b0}}};
    localparam logic [c_DW-1:0] c_MAX  = ~c_MIN;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [2:0]              r_op;
    logic signed [c_DW-1:0]  r_scalar;
    logic [c_MW-1:0]         r_a;
    logic [c_MW-1:0]         r_b;
    logic [c_MW-1:0]         r_result;
    logic                    r_ovf;
    logic [c_IW-1:0]         r_row;
    logic [c_IW-1:0]         r_col;
    logic [c_IW-1:0]         r_k;
    logic signed [c_AW-1:0]  r_acc;

    logic                    w_legal;
    logic                    w_is_mm;
    logic                    w_step;
    logic                    w_last;
    logic [c_XW-1:0]         w_idx_rc;
    logic [c_XW-1:0]         w_idx_cr;
    logic [c_XW-1:0]         w_idx_rk;
    logic [c_XW-1:0]         w_idx_kc;
    logic signed [c_DW-1:0]  w_a_rc;
    logic signed [c_DW-1:0]  w_b_rc;
    logic signed [c_DW-1:0]  w_a_cr;
    logic signed [c_DW-1:0]  w_a_rk;
    logic signed [c_DW-1:0]  w_b_kc;
    logic signed [c_PW-1:0]  w_prod_s;
    logic signed [c_PW-1:0]  w_prod_m;
    logic signed [c_AW-1:0]  w_acc_nxt;
    logic signed [c_AW-1:0]  w_wide;
    logic [c_AW-c_DW:0]      w_top;
    logic                    w_el_ovf;
    logic [c_DW-1:0]         w_res_el;

    assign w_legal  = (i_operation != 3'b000) && (i_operation <= c_OP_MM);
    assign w_is_mm  = (r_op == c_OP_MM);
    assign w_step   = !w_is_mm || (r_k == c_DMAX);
    assign w_last   = (r_row == c_DMAX) && (r_col == c_DMAX) && w_step;

    assign w_idx_rc = c_XW'(r_row) * c_XW'(DIM) + c_XW'(r_col);
    assign w_idx_cr = c_XW'(r_col) * c_XW'(DIM) + c_XW'(r_row);
    assign w_idx_rk = c_XW'(r_row) * c_XW'(DIM) + c_XW'(r_k);
    assign w_idx_kc = c_XW'(r_k)   * c_XW'(DIM) + c_XW'(r_col);

    assign w_a_rc   = r_a[w_idx_rc*c_DW +: c_DW];
    assign w_b_rc   = r_b[w_idx_rc*c_DW +: c_DW];
    assign w_a_cr   = r_a[w_idx_cr*c_DW +: c_DW];
    assign w_a_rk   = r_a[w_idx_rk*c_DW +: c_DW];
    assign w_b_kc   = r_b[w_idx_kc*c_DW +: c_DW];

    assign w_prod_s  = c_PW'(r_scalar) * c_PW'(w_a_rc);
    assign w_prod_m  = c_PW'(w_a_rk) * c_PW'(w_b_kc);
    assign w_acc_nxt = (r_k == '0) ? c_AW'(w_prod_m) : r_acc + c_AW'(w_prod_m);

    always_comb begin
        w_wide = '0;
        case (r_op)
            c_OP_ADD:  w_wide = c_AW'(w_a_rc) + c_AW'(w_b_rc);
            c_OP_SUB:  w_wide = c_AW'(w_a_rc) - c_AW'(w_b_rc);
            c_OP_TRAN: w_wide = c_AW'(w_a_cr);
            c_OP_SMUL: w_wide = c_AW'(w_prod_s);
            c_OP_MM:   w_wide = w_acc_nxt;
            default:   w_wide = '0;
        endcase
    end

    // The value fits in DATA_WIDTH only if every bit above the sign bit matches it.
    assign w_top    = w_wide[c_AW-1:c_DW-1];
    assign w_el_ovf = ~((&w_top) | ~(|w_top));
    assign w_res_el = ((SATURATE != 0) && w_el_ovf) ? (w_wide[c_AW-1] ? c_MIN : c_MAX)
                                                    : w_wide[c_DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (i_enable) w_state_nxt = w_legal ? c_COMPUTE : c_FINISH;
            c_COMPUTE: if (w_last)   w_state_nxt = c_FINISH;
            c_FINISH:  w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            c_COMPUTE: o_busy = 1'b1;
            c_FINISH:  o_done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_scalar <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_k      <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_enable) begin
                        r_ovf <= 1'b0;
                        if (w_legal) begin
                            r_op     <= i_operation;
                            r_scalar <= i_scalar;
                            r_a      <= i_matrix_a;
                            r_b      <= i_matrix_b;
                            r_row    <= '0;
                            r_col    <= '0;
                            r_k      <= '0;
                            r_acc    <= '0;
                        end
                    end
                end
                c_COMPUTE: begin
                    if (w_is_mm) begin
                        r_acc <= w_acc_nxt;
                        r_k   <= (r_k == c_DMAX) ? '0 : r_k + 1'b1;
                    end
                    if (w_step) begin
                        r_result[w_idx_rc*c_DW +: c_DW] <= w_res_el;
                        r_ovf <= r_ovf | w_el_ovf;
                        if (r_col == c_DMAX) begin
                            r_col <= '0;
                            r_row <= (r_row == c_DMAX) ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result   = r_result;
    assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_matrix_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_alu_seq
// Brief    : Directed self-checking bench for matrix_alu_seq (saturating and
//            wrapping instances driven from the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_alu_seq;

    localparam int c_N  = 4;
    localparam int c_DW = 32;
    localparam int c_MW = c_N*c_N*c_DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_enable = 1'b0;
    logic [2:0]        i_operation = 3'b000;
    logic [c_DW-1:0]   i_scalar = '0;
    logic [c_MW-1:0]   i_matrix_a = '0;
    logic [c_MW-1:0]   i_matrix_b = '0;
    logic [c_MW-1:0]   o_result, o_result_w;
    logic              o_busy, o_busy_w;
    logic              o_done, o_done_w;
    logic              o_overflow, o_overflow_w;

    int checks = 0;
    int errors = 0;
    int lat, busy_n;
    logic [c_MW-1:0] exp_m;
    logic [c_DW-1:0] el;

    always #5 clk = ~clk;

    matrix_alu_seq #(.DIM(c_N), .DATA_WIDTH(c_DW), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_operation(i_operation),
        .i_scalar(i_scalar), .i_matrix_a(i_matrix_a), .i_matrix_b(i_matrix_b),
        .o_result(o_result), .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
    );

    matrix_alu_seq #(.DIM(c_N), .DATA_WIDTH(c_DW), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_operation(i_operation),
        .i_scalar(i_scalar), .i_matrix_a(i_matrix_a), .i_matrix_b(i_matrix_b),
        .o_result(o_result_w), .o_busy(o_busy_w), .o_done(o_done_w), .o_overflow(o_overflow_w)
    );

    function automatic logic [c_MW-1:0] fill(input logic [c_DW-1:0] v);
        logic [c_MW-1:0] m;
        for (int i = 0; i < c_N*c_N; i++) m[i*c_DW +: c_DW] = v;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [c_MW-1:0] obs, input logic [c_MW-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Start an operation and count negedges until Done; cycle 1 is the one after the start edge.
    task automatic run(input logic [2:0] op, input int pulse_at, output int lat_o, output int busy_o);
        lat_o  = -1;
        busy_o = 0;
        @(negedge clk);
        i_operation = op;
        i_enable    = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                i_enable = 1'b0;
                if (pulse_at > 0) i_matrix_a = ~i_matrix_a;
            end
            if (pulse_at > 0 && n == pulse_at)     i_enable = 1'b1;
            if (pulse_at > 0 && n == pulse_at + 1) i_enable = 1'b0;
            if (o_busy) busy_o++;
            if (o_done) begin
                lat_o = n;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_result", o_result, '0);
        chk("reset_flags", {o_busy, o_done, o_overflow}, 3'b000);
        rst_n = 1'b1;

        // Add 25 + 2
        i_matrix_a = fill(32'd25);
        i_matrix_b = fill(32'd2);
        run(3'b001, 0, lat, busy_n);
        chk("add_result", o_result, fill(32'd27));
        chk("add_latency", lat, 17);
        chk("add_busy_cycles", busy_n, 16);
        chk("add_overflow", o_overflow, 1'b0);

        // Subtract with underflow in element (0,0)
        i_matrix_a = fill(32'd5);
        i_matrix_b = fill(32'd3);
        i_matrix_a[0 +: c_DW] = 32'h8000_0000;
        i_matrix_b[0 +: c_DW] = 32'd1;
        run(3'b010, 0, lat, busy_n);
        exp_m = fill(32'd2);
        exp_m[0 +: c_DW] = 32'h8000_0000;
        chk("sub_sat_result", o_result, exp_m);
        chk("sub_sat_overflow", o_overflow, 1'b1);
        exp_m[0 +: c_DW] = 32'h7FFF_FFFF;
        chk("sub_wrap_result", o_result_w, exp_m);
        chk("sub_wrap_overflow", o_overflow_w, 1'b1);

        // Transpose
        for (int r = 0; r < c_N; r++)
            for (int c = 0; c < c_N; c++) begin
                i_matrix_a[(r*c_N+c)*c_DW +: c_DW] = 32'(r*4 + c);
                exp_m[(r*c_N+c)*c_DW +: c_DW]      = 32'(c*4 + r);
            end
        run(3'b011, 0, lat, busy_n);
        chk("tran_result", o_result, exp_m);
        el = o_result[(1*c_N+3)*c_DW +: c_DW];
        chk("tran_elem_1_3", el, 32'd13);
        chk("tran_overflow", o_overflow, 1'b0);

        // ScalarMultiply -3 * 25
        i_scalar   = -32'sd3;
        i_matrix_a = fill(32'd25);
        run(3'b100, 0, lat, busy_n);
        chk("smul_result", o_result, fill(-32'sd75));
        chk("smul_latency", lat, 17);

        // MatrixMultiply identity * B
        i_matrix_a = '0;
        for (int r = 0; r < c_N; r++) begin
            i_matrix_a[(r*c_N+r)*c_DW +: c_DW] = 32'd1;
            for (int c = 0; c < c_N; c++) i_matrix_b[(r*c_N+c)*c_DW +: c_DW] = 32'(r - c);
        end
        exp_m = i_matrix_b;
        run(3'b101, 0, lat, busy_n);
        chk("mm_ident_result", o_result, exp_m);
        chk("mm_ident_latency", lat, 65);
        chk("mm_ident_busy_cycles", busy_n, 64);

        // MatrixMultiply 2s * 3s
        i_matrix_a = fill(32'd2);
        i_matrix_b = fill(32'd3);
        run(3'b101, 0, lat, busy_n);
        chk("mm_const_result", o_result, fill(32'd24));
        chk("mm_const_overflow", o_overflow, 1'b0);

        // MatrixMultiply overflow: 4 * (2^30 * 4) = 2^34
        i_matrix_a = fill(32'h4000_0000);
        i_matrix_b = fill(32'd4);
        run(3'b101, 0, lat, busy_n);
        chk("mm_sat_result", o_result, fill(32'h7FFF_FFFF));
        chk("mm_sat_overflow", o_overflow, 1'b1);
        chk("mm_wrap_result", o_result_w, '0);
        chk("mm_wrap_overflow", o_overflow_w, 1'b1);

        // Re-pulse Enable mid-operation and disturb operand A after the start edge
        i_matrix_a = fill(32'd2);
        i_matrix_b = fill(32'd3);
        run(3'b101, 10, lat, busy_n);
        chk("mm_pulse_result", o_result, fill(32'd24));
        chk("mm_pulse_latency", lat, 65);

        // Illegal opcode 000
        run(3'b000, 0, lat, busy_n);
        chk("illegal_latency", lat, 1);
        chk("illegal_result_kept", o_result, fill(32'd24));
        chk("illegal_busy_cycles", busy_n, 0);
        chk("illegal_overflow", o_overflow, 1'b0);

        // Asynchronous reset 30 cycles into a MatrixMultiply
        i_matrix_a = fill(32'd7);
        @(negedge clk);
        i_operation = 3'b101;
        i_enable    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_enable = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_reset_busy", o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_result", o_result, '0);
        chk("async_reset_flags", {o_busy, o_done, o_overflow}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // Add after reset release
        i_matrix_a = fill(32'd25);
        i_matrix_b = fill(32'd2);
        run(3'b001, 0, lat, busy_n);
        chk("post_reset_add_result", o_result, fill(32'd27));
        chk("post_reset_add_latency", lat, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
